// File: rtl/sprite_rom_arbiter.sv
// Two-requester arbiter sharing one pipelined sprite ROM.
// A tag pipeline routes each returned word back to the requester that issued it.
module sprite_rom_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prio,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int unsigned TAG_N = ROM_LAT + 1;

  logic              last_id;
  logic              rom_id;
  logic              accept;
  logic [TAG_N-1:0]  tag_v;
  logic [TAG_N-1:0]  tag_id;
  logic [DATA_W-1:0] rom_q;

  // Fixed priority to requester 0, or alternate against the last winner.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (prio) begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
      end else if (req0 && req1) begin
        gnt0 = last_id;
        gnt1 = ~last_id;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign accept = gnt0 | gnt1;

  // ROM issue register and last-grant pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
      rom_id   <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      rom_en <= accept;
      if (accept) begin
        rom_addr <= gnt1 ? addr1 : addr0;
        rom_id   <= gnt1;
        last_id  <= gnt1;
      end
    end
  end

  // Tag pipeline follows the read; rom_data is registered so the last tag
  // stage lines up with the word the ROM produced for that read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
      rom_q  <= '0;
    end else begin
      tag_v  <= {tag_v[TAG_N-2:0], rom_en};
      tag_id <= {tag_id[TAG_N-2:0], rom_id};
      rom_q  <= rom_data;
    end
  end

  // Return stage: rdata holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= tag_v[TAG_N-1] & ~tag_id[TAG_N-1];
      rvalid1 <= tag_v[TAG_N-1] & tag_id[TAG_N-1];
      if (tag_v[TAG_N-1]) begin
        rdata <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: three instances (ROM_LAT 1, 2, 4) share stimulus
// and are compared every cycle against an accept-log model of the arbiter.
module tb_sprite_rom_arbiter;

  logic clk;
  logic rst;
  logic prio;
  logic req0;
  logic req1;
  logic [11:0] addr0;
  logic [11:0] addr1;

  logic [2:0] g0;
  logic [2:0] g1;
  logic [2:0] rv0;
  logic [2:0] rv1;
  logic [2:0] ren;
  logic [2:0][11:0] rd;
  logic [2:0][11:0] ra;
  logic [2:0][11:0] rdat;

  int n_vec;
  int n_err;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [11:0] rom_word(input logic [11:0] a);
    return {a[3:0], a[11:4]} ^ 12'h0F0;
  endfunction

  sprite_rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .prio(prio), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(g0[0]), .gnt1(g1[0]),
    .rvalid0(rv0[0]), .rvalid1(rv1[0]), .rdata(rd[0]),
    .rom_addr(ra[0]), .rom_en(ren[0]), .rom_data(rdat[0]));

  sprite_rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .prio(prio), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(g0[1]), .gnt1(g1[1]),
    .rvalid0(rv0[1]), .rvalid1(rv1[1]), .rdata(rd[1]),
    .rom_addr(ra[1]), .rom_en(ren[1]), .rom_data(rdat[1]));

  sprite_rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(4)) u_l4 (
    .clk(clk), .rst(rst), .prio(prio), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(g0[2]), .gnt1(g1[2]),
    .rvalid0(rv0[2]), .rvalid1(rv1[2]), .rdata(rd[2]),
    .rom_addr(ra[2]), .rom_en(ren[2]), .rom_data(rdat[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM environment: word for the address presented ROM_LAT cycles earlier.
  logic [11:0] hst [3][4];
  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) hst[k][i] = 12'h000;
  end
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      hst[k][0] <= ra[k];
      for (int i = 1; i < 4; i++) hst[k][i] <= hst[k][i-1];
    end
  end
  assign rdat[0] = rom_word(hst[0][0]);
  assign rdat[1] = rom_word(hst[1][1]);
  assign rdat[2] = rom_word(hst[2][3]);

  // Model: grant rule, log of accepts, and per-latency return pointers.
  logic        m_last;
  logic        exp_rom_en;
  logic [11:0] exp_rom_addr;
  logic [2:0]  exp_rv0;
  logic [2:0]  exp_rv1;
  logic [11:0] exp_rdata [3];
  int          log_cyc  [1024];
  logic        log_id   [1024];
  logic [11:0] log_addr [1024];
  int          log_n;
  int          rp [3];
  int          cyc;

  initial begin
    m_last = 1'b1; exp_rom_en = 1'b0; exp_rom_addr = 12'h000;
    exp_rv0 = 3'b000; exp_rv1 = 3'b000;
    for (int k = 0; k < 3; k++) begin exp_rdata[k] = 12'h000; rp[k] = 0; end
    log_n = 0; cyc = 0;
  end

  function automatic logic [1:0] mgnt();
    if (rst) return 2'b00;
    if (req0 && req1) begin
      if (prio) return 2'b01;
      return m_last ? 2'b01 : 2'b10;
    end
    return {req1, req0};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_last       <= 1'b1;
      exp_rom_en   <= 1'b0;
      exp_rom_addr <= 12'h000;
      exp_rv0      <= 3'b000;
      exp_rv1      <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        exp_rdata[k] <= 12'h000;
        rp[k]        <= log_n;
      end
    end else begin
      exp_rom_en <= |mgnt();
      if (|mgnt()) begin
        m_last          <= mgnt() == 2'b10;
        exp_rom_addr    <= (mgnt() == 2'b10) ? addr1 : addr0;
        log_cyc[log_n]  <= cyc;
        log_id[log_n]   <= mgnt() == 2'b10;
        log_addr[log_n] <= (mgnt() == 2'b10) ? addr1 : addr0;
        log_n           <= log_n + 1;
      end
      for (int k = 0; k < 3; k++) begin
        if (rp[k] < log_n && log_cyc[rp[k]] + lat(k) + 2 == cyc) begin
          exp_rv0[k]   <= !log_id[rp[k]];
          exp_rv1[k]   <= log_id[rp[k]];
          exp_rdata[k] <= rom_word(log_addr[rp[k]]);
          rp[k]        <= rp[k] + 1;
        end else begin
          exp_rv0[k] <= 1'b0;
          exp_rv1[k] <= 1'b0;
        end
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lat%0d t=%0t got %h want %h", nm, lat(k), $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("gnt0", k, 32'(g0[k]), 32'(mgnt() == 2'b01));
      chk("gnt1", k, 32'(g1[k]), 32'(mgnt() == 2'b10));
      chk("rvalid0", k, 32'(rv0[k]), rst ? 32'd0 : 32'(exp_rv0[k]));
      chk("rvalid1", k, 32'(rv1[k]), rst ? 32'd0 : 32'(exp_rv1[k]));
      chk("rdata", k, 32'(rd[k]), rst ? 32'd0 : 32'(exp_rdata[k]));
      chk("rom_en", k, 32'(ren[k]), rst ? 32'd0 : 32'(exp_rom_en));
      chk("rom_addr", k, 32'(ra[k]), rst ? 32'd0 : 32'(exp_rom_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] pg;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; prio = 1'b0; req0 = 1'b1; req1 = 1'b1;
    addr0 = 12'h000; addr1 = 12'h000;
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("lit_rst_gnt0", k, 32'(g0[k]), 32'd0);
      chk("lit_rst_rom_addr", k, 32'(ra[k]), 32'd0);
      chk("lit_rst_rdata", k, 32'(rd[k]), 32'd0);
    end
    tick();

    // Single request after reset, latency pinned per instance.
    rst = 1'b0; req0 = 1'b1; addr0 = 12'h123; req1 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("lit_first_gnt0", k, 32'(g0[k]), 32'd1);
    tick();
    req0 = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (e == 0) begin
          chk("lit_rom_addr", k, 32'(ra[k]), 32'h123);
          chk("lit_rom_en", k, 32'(ren[k]), 32'd1);
        end
        chk("lit_rvalid0_lat", k, 32'(rv0[k]), 32'(e == lat(k) + 2));
        if (e == lat(k) + 2) chk("lit_rdata_123", k, 32'(rd[k]), 32'h3E2);
      end
      tick();
    end

    // Round-robin with both requesting.
    rst = 1'b1; tick(); rst = 1'b0;
    addr0 = 12'h0AB; addr1 = 12'h0CD;
    for (int i = 0; i < 12; i++) begin
      req0 = (i < 6); req1 = (i < 6);
      @(negedge clk);
      if (i < 6) begin
        chk("lit_rr_gnt0", 1, 32'(g0[1]), 32'(i % 2 == 0));
        chk("lit_rr_gnt1", 1, 32'(g1[1]), 32'(i % 2 == 1));
      end
      chk("lit_rr_rvalid0", 1, 32'(rv0[1]), 32'(i == 5 || i == 7 || i == 9));
      chk("lit_rr_rvalid1", 1, 32'(rv1[1]), 32'(i == 6 || i == 8 || i == 10));
      tick();
    end

    // Fixed priority, then requester 0 drops.
    prio = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0 = (i < 4); req1 = (i < 5);
      @(negedge clk);
      if (i < 4) begin
        chk("lit_prio_gnt0", 1, 32'(g0[1]), 32'd1);
        chk("lit_prio_gnt1", 1, 32'(g1[1]), 32'd0);
      end else if (i == 4) begin
        chk("lit_prio_gnt1_alone", 1, 32'(g1[1]), 32'd1);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; prio = 1'b0;
    repeat (8) tick();

    // Reset just before the first response discards every in-flight read.
    for (int i = 0; i < 3; i++) begin
      req0 = 1'b1; addr0 = 12'(16 * (i + 1));
      tick();
    end
    req0 = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("lit_flush_rv_l2", 1, 32'(rv0[1]), 32'd0);
      chk("lit_flush_rv_l4", 2, 32'(rv0[2]), 32'd0);
      chk("lit_flush_rdata", 1, 32'(rd[1]), 32'd0);
      tick();
    end
    req0 = 1'b1; addr0 = 12'h7FF;
    tick();
    req0 = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      chk("lit_post_rst_rv", 1, 32'(rv0[1]), 32'(e == 4));
      if (e == 4) chk("lit_post_rst_rdata", 1, 32'(rd[1]), 32'hF8F);
      tick();
    end

    // Random traffic; addresses held until the model says the request was taken.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      pg = mgnt();
      tick();
      rst = ($urandom_range(0, 79) == 0);
      if (c % 25 == 0) prio = 1'($urandom_range(0, 1));
      if (!req0 || pg[0]) begin
        req0 = ($urandom_range(0, 2) != 0);
        addr0 = 12'($urandom);
      end
      if (!req1 || pg[1]) begin
        req1 = ($urandom_range(0, 2) != 0);
        addr1 = 12'($urandom);
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 12, meaning ROM word width (4:4:4 RGB).
REQ-003 The block SHALL have parameter ROM_LAT, default 2, legal range 1..4, meaning cycles from rom_addr/rom_en presented to matching rom_data.
REQ-004 The block SHALL have port clk, input, 1, the single clock (pclk domain); one clock, no other clock.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 The block SHALL have port prio, input, 1, meaning requester 0 has fixed priority when high and round-robin applies when low.
REQ-007 The block SHALL have ports req0 and req1, input, 1 each, meaning the requester holds a read request.
REQ-008 The block SHALL have ports addr0 and addr1, input, ADDR_W each, meaning read address, stable while reqN is high.
REQ-009 The block SHALL have ports gnt0 and gnt1, output, 1 each, combinational, meaning the request is accepted at this rising edge.
REQ-010 The block SHALL have ports rvalid0 and rvalid1, output, 1 each, registered, meaning rdata holds the word for that requester.
REQ-011 The block SHALL have port rdata, output, DATA_W, registered, meaning the returned ROM word, shared by both requesters.
REQ-012 The block SHALL have port rom_addr, output, ADDR_W, registered, meaning the address to the single-port ROM.
REQ-013 The block SHALL have port rom_en, output, 1, registered, meaning rom_addr is a valid read this cycle.
REQ-014 The block SHALL have port rom_data, input, DATA_W, meaning the ROM output corresponding to rom_addr from ROM_LAT cycles earlier.

Function
REQ-015 The block SHALL assert at most one of gnt0/gnt1 per cycle; a gnt SHALL only be asserted while its reqN is high.
REQ-016 A request SHALL be accepted at a rising edge where reqN and gntN are both high; the requester may change addrN or drop reqN after that edge.
REQ-017 With prio high, gnt0 SHALL equal req0, and gnt1 SHALL equal req1 and not req0.
REQ-018 With prio low and both requesting, the grant SHALL go to the requester not granted most recently; a single requester SHALL be granted every cycle (no bubbles).
REQ-019 The last-grant pointer SHALL update only on an accept, and SHALL update in both prio modes.
REQ-020 On an accept, rom_addr SHALL load the winner's address and rom_en SHALL be 1 in the next cycle; with no accept, rom_en SHALL be 0 and rom_addr SHALL hold.
REQ-021 The block SHALL carry a ROM_LAT+1 stage tag pipeline (valid, id) alongside each issued read, advancing every cycle with no stall.
REQ-022 rdata SHALL capture rom_data, and rvalidN SHALL pulse for one cycle exactly ROM_LAT+2 rising edges after the accept edge.
REQ-023 Responses SHALL return in issue order; back-to-back accepts SHALL yield back-to-back rvalid pulses.
REQ-024 rvalid0 and rvalid1 SHALL never be high together.
REQ-025 rdata SHALL hold its value when neither rvalid is high.
REQ-026 A prio change SHALL affect only arbitration from the next edge and SHALL NOT drop or reorder in-flight reads.

Reset
REQ-027 While rst is high: gnt0=gnt1=0, rvalid0=rvalid1=0, rom_en=0, rom_addr=0, rdata=0, all tag valids cleared, last-grant pointer=1 (requester 0 wins first).
REQ-028 rst asserted mid-operation SHALL discard all in-flight reads; no rvalid SHALL appear for reads accepted before reset.
REQ-029 Arbitration SHALL resume on the first edge after rst deasserts.

Verification
REQ-030 Reset then req0=1, addr0=0x123, req1=0, ROM_LAT=2 -> gnt0=1 immediately; rom_addr=0x123 and rom_en=1 next cycle; rvalid0=1 with rdata=ROM[0x123] four edges after accept.
REQ-031 prio=0, req0 and req1 held high for 6 cycles -> grants alternate 0,1,0,1,0,1; rvalid sequence matches 0,1,0,1,0,1 with no gaps.
REQ-032 prio=1, both held high for 4 cycles -> gnt0 every cycle, gnt1 never; then req0 dropped -> gnt1 on that same cycle.
REQ-033 Three accepts issued, rst pulsed one cycle before the first rvalid -> no rvalid ever appears; outputs at reset values; a new req0 afterwards completes normally.
REQ-034 Sweep ROM_LAT over 1 and 4 with random req/addr traffic -> a scoreboard confirms in-order data, latency ROM_LAT+2, and one-hot gnt/rvalid.
